// File: rtl/fir_coef_ctrl.sv
// FIR coefficient reload controller: shadows a full coefficient set, drains the
// in-flight samples, then writes the set into the FIR while sample flow is stalled.
//
// state    | meaning
// UNLOADED | no set written yet, samples blocked, collecting first set
// RUN      | samples flow, next set may be collected in the shadow buffer
// DRAIN    | shadow full, samples blocked, waiting for the FIR to empty
// WRITE    | streaming shadow words into the FIR coefficient port
module fir_coef_ctrl #(
    parameter int TAP_CNT      = 31,
    parameter int DATA_W       = 32,
    parameter int MAX_INFLIGHT = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_valid,
    input  logic [DATA_W-1:0]                 cfg_data,
    output logic                              cfg_ready,
    input  logic                              s_valid,
    input  logic [DATA_W-1:0]                 s_data,
    output logic                              s_ready,
    output logic                              fir_valid_in,
    output logic [DATA_W-1:0]                 fir_data_in,
    input  logic                              fir_valid_out,
    output logic                              coef_we,
    output logic [$clog2(TAP_CNT)-1:0]        coef_addr,
    output logic [DATA_W-1:0]                 coef_wdata,
    output logic                              loaded,
    output logic                              cnt_err
);

    localparam int AW = $clog2(TAP_CNT);
    localparam int CW = $clog2(TAP_CNT + 1);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        UNLOADED = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2,
        WRITE    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     shadow_cnt;
    logic [CW-1:0]     shadow_cnt_nxt;
    logic [IW-1:0]     inflight;
    logic [IW-1:0]     inflight_nxt;
    logic [IW:0]       issued_nxt;
    logic [DATA_W-1:0] shadow [TAP_CNT];
    logic              cfg_acc;
    logic              s_acc;
    logic              underflow;
    logic              write_done;
    logic              shadow_full;

    always_comb begin
        cfg_acc     = cfg_valid & cfg_ready;
        s_acc       = s_valid & s_ready;
        shadow_full = (shadow_cnt == CW'(TAP_CNT));
        write_done  = (state == WRITE) && (coef_addr == AW'(TAP_CNT - 1));
        underflow   = fir_valid_out && !fir_valid_in && (inflight == '0);

        inflight_nxt = inflight;
        if (fir_valid_in && !fir_valid_out)
            inflight_nxt = inflight + 1'b1;
        else if (fir_valid_out && !fir_valid_in && (inflight != '0))
            inflight_nxt = inflight - 1'b1;

        shadow_cnt_nxt = shadow_cnt;
        if (write_done)
            shadow_cnt_nxt = '0;
        else if (cfg_acc)
            shadow_cnt_nxt = shadow_cnt + 1'b1;

        state_nxt = state;
        case (state)
            UNLOADED: if (shadow_full) state_nxt = WRITE;
            RUN:      if (shadow_full) state_nxt = DRAIN;
            // a sample issued on the last RUN cycle is not yet counted in inflight
            DRAIN:    if ((inflight == '0) && !fir_valid_in) state_nxt = WRITE;
            WRITE:    if (write_done) state_nxt = RUN;
            default:  state_nxt = UNLOADED;
        endcase

        // include the sample being accepted now, which lands in inflight two edges later
        issued_nxt = {1'b0, inflight_nxt} + {{IW{1'b0}}, s_acc};
    end

    always_ff @(posedge clk) begin
        if (cfg_acc)
            shadow[shadow_cnt[AW-1:0]] <= cfg_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= UNLOADED;
            shadow_cnt   <= '0;
            inflight     <= '0;
            cfg_ready    <= 1'b0;
            s_ready      <= 1'b0;
            fir_valid_in <= 1'b0;
            fir_data_in  <= '0;
            coef_we      <= 1'b0;
            coef_addr    <= '0;
            coef_wdata   <= '0;
            loaded       <= 1'b0;
            cnt_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            shadow_cnt <= shadow_cnt_nxt;
            inflight   <= inflight_nxt;
            if (underflow)
                cnt_err <= 1'b1;

            cfg_ready <= (shadow_cnt_nxt < CW'(TAP_CNT)) && (state_nxt != WRITE);
            s_ready   <= (state_nxt == RUN) && (shadow_cnt_nxt < CW'(TAP_CNT)) &&
                         (issued_nxt < (IW + 1)'(MAX_INFLIGHT));

            fir_valid_in <= s_acc;
            if (s_acc)
                fir_data_in <= s_data;

            if ((state != WRITE) && (state_nxt == WRITE)) begin
                coef_we    <= 1'b1;
                coef_addr  <= '0;
                coef_wdata <= shadow[0];
            end else if (write_done) begin
                coef_we <= 1'b0;
                loaded  <= 1'b1;
            end else if (state == WRITE) begin
                coef_addr  <= coef_addr + 1'b1;
                coef_wdata <= shadow[coef_addr + 1'b1];
            end
        end
    end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: load, streaming, reload drain, inflight limit,
// underflow flag and reset in the middle of a coefficient write.
module tb_fir_coef_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_data = '0;
    logic        cfg_ready;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic        fir_valid_in;
    logic [31:0] fir_data_in;
    logic        fir_valid_out;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [31:0] coef_wdata;
    logic        loaded;
    logic        cnt_err;

    logic        man_out = 1'b0;
    logic        model_en = 1'b0;
    logic [9:0]  pipe = '0;

    logic        s4_valid = 1'b0;
    logic [31:0] s4_data = '0;
    logic        s4_ready;
    logic        fvi4;
    logic [31:0] fdi4;
    logic        fo4 = 1'b0;
    logic        cw4;
    logic [4:0]  ca4;
    logic [31:0] cd4;
    logic        cfgr4;
    logic        loaded4;
    logic        err4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // FIR model: each issued sample returns ten cycles later
    always @(negedge clk) begin
        if (!model_en) pipe = '0;
        else           pipe = {pipe[8:0], fir_valid_in};
    end

    assign fir_valid_out = model_en ? pipe[9] : man_out;

    fir_coef_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fir_valid_in(fir_valid_in), .fir_data_in(fir_data_in),
        .fir_valid_out(fir_valid_out),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .loaded(loaded), .cnt_err(cnt_err)
    );

    fir_coef_ctrl #(.TAP_CNT(31), .DATA_W(32), .MAX_INFLIGHT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfgr4),
        .s_valid(s4_valid), .s_data(s4_data), .s_ready(s4_ready),
        .fir_valid_in(fvi4), .fir_data_in(fdi4),
        .fir_valid_out(fo4),
        .coef_we(cw4), .coef_addr(ca4), .coef_wdata(cd4),
        .loaded(loaded4), .cnt_err(err4)
    );

    // sends 31 words starting at base; called and returns at a falling edge
    task automatic send_cfg(input logic [31:0] base);
        int guard;
        bit timeout = 0;
        for (int i = 0; i < 31; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = base + 32'(i);
            guard = 0;
            while (cfg_ready !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) timeout = 1;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        tests++;
        if (timeout) begin
            fails++;
            $display("FAIL cfg_send_timeout: got cfg_ready stuck low, expected acceptance");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({cfg_ready, s_ready, fir_valid_in, coef_we, loaded, cnt_err} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {cfg_ready, s_ready, fir_valid_in, coef_we, loaded, cnt_err});
        end
        tests++;
        if (coef_addr !== 5'd0 || coef_wdata !== 32'd0 || fir_data_in !== 32'd0) begin
            fails++;
            $display("FAIL reset_data: got addr %0h wdata %0h fdi %0h expected 0",
                     coef_addr, coef_wdata, fir_data_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (cfg_ready !== 1'b1 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got cfg_ready %b s_ready %b expected 1 0",
                     cfg_ready, s_ready);
        end
    endtask

    task automatic test_load();
        int nwr = 0;
        int cyc = 0;
        bit gap = 0;
        send_cfg(32'h3F80_0000);
        tests++;
        if (cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL load_cfg_ready_drop: got %b expected 0", cfg_ready);
        end
        while (nwr < 31 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (coef_we === 1'b1) begin
                tests++;
                if (coef_addr !== 5'(nwr) || coef_wdata !== 32'h3F80_0000 + 32'(nwr) ||
                    loaded !== 1'b0 || s_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL load_write: got addr %0d data %0h loaded %b expected addr %0d data %0h loaded 0",
                             coef_addr, coef_wdata, loaded, nwr, 32'h3F80_0000 + 32'(nwr));
                end
                nwr++;
            end else if (nwr > 0) begin
                gap = 1;
            end
        end
        tests++;
        if (nwr != 31 || gap) begin
            fails++;
            $display("FAIL load_write_count: got %0d writes gap %b expected 31 contiguous", nwr, gap);
        end
        @(negedge clk);
        tests++;
        if (coef_we !== 1'b0 || loaded !== 1'b1 || s_ready !== 1'b1 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL load_done: got we %b loaded %b s_ready %b cfg_ready %b expected 0 1 1 1",
                     coef_we, loaded, s_ready, cfg_ready);
        end
    endtask

    task automatic test_max_inflight();
        int n = 0;
        int m = 0;
        tests++;
        if (loaded4 !== 1'b1 || cfgr4 !== 1'b1 || ca4 !== 5'd30 || cd4 !== 32'h3F80_001E) begin
            fails++;
            $display("FAIL max_loaded: got loaded %b cfg_ready %b addr %0d data %0h expected 1 1 30 3f80001e",
                     loaded4, cfgr4, ca4, cd4);
        end
        s4_valid = 1'b1;
        s4_data  = 32'hABCD_0001;
        repeat (20) begin
            @(negedge clk);
            if (fvi4 === 1'b1) n++;
        end
        tests++;
        if (n != 4 || s4_ready !== 1'b0) begin
            fails++;
            $display("FAIL max_issue: got %0d issued s_ready %b expected 4 issued s_ready 0", n, s4_ready);
        end
        fo4 = 1'b1;
        @(negedge clk);
        fo4 = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (fvi4 === 1'b1) m++;
        end
        s4_valid = 1'b0;
        tests++;
        if (m != 1 || s4_ready !== 1'b0) begin
            fails++;
            $display("FAIL max_one_more: got %0d issued s_ready %b expected 1 issued s_ready 0", m, s4_ready);
        end
        tests++;
        if (fdi4 !== 32'hABCD_0001 || cw4 !== 1'b0 || err4 !== 1'b0) begin
            fails++;
            $display("FAIL max_side: got data %0h we %b err %b expected abcd0001 0 0", fdi4, cw4, err4);
        end
    endtask

    task automatic test_stream();
        int k = 0;
        int pulses = 0;
        int cyc = 0;
        bit acc;
        logic [31:0] acc_d;
        model_en = 1'b1;
        while (k < 100 && cyc < 300) begin
            s_valid = 1'b1;
            s_data  = 32'h3000_0000 + 32'(k * 7);
            acc   = (s_ready === 1'b1);
            acc_d = s_data;
            @(negedge clk);
            cyc++;
            if (fir_valid_in === 1'b1) pulses++;
            tests++;
            if (fir_valid_in !== acc || (acc && fir_data_in !== acc_d)) begin
                fails++;
                $display("FAIL stream_issue: got valid %b data %0h expected valid %b data %0h",
                         fir_valid_in, fir_data_in, acc, acc_d);
            end
            if (acc) k++;
        end
        s_valid = 1'b0;
        tests++;
        if (pulses != 100 || cyc != 100) begin
            fails++;
            $display("FAIL stream_count: got %0d pulses in %0d cycles expected 100 in 100", pulses, cyc);
        end
        repeat (15) @(negedge clk);
        tests++;
        if (dut.inflight !== 7'd0 || cnt_err !== 1'b0) begin
            fails++;
            $display("FAIL stream_drain: got inflight %0d cnt_err %b expected 0 0", dut.inflight, cnt_err);
        end
        model_en = 1'b0;
    endtask

    task automatic test_reload();
        int n = 0;
        int guard = 0;
        int nwr = 0;
        int cyc = 0;
        bit bad = 0;
        s_valid = 1'b1;
        while (n < 5 && guard < 50) begin
            s_data = 32'h5500_0000 + 32'(n);
            if (s_ready === 1'b1) n++;
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (dut.inflight !== 7'd5) begin
            fails++;
            $display("FAIL reload_inflight: got %0d expected 5", dut.inflight);
        end
        send_cfg(32'h4000_0000);
        tests++;
        if (s_ready !== 1'b0) begin
            fails++;
            $display("FAIL reload_stall: got s_ready %b expected 0", s_ready);
        end
        repeat (5) begin
            @(negedge clk);
            if (coef_we !== 1'b0 || s_ready !== 1'b0) bad = 1;
        end
        for (int p = 0; p < 5; p++) begin
            man_out = 1'b1;
            @(negedge clk);
            man_out = 1'b0;
            if (p < 4) begin
                repeat (3) begin
                    @(negedge clk);
                    if (coef_we !== 1'b0 || s_ready !== 1'b0) bad = 1;
                end
            end
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reload_drain_hold: got early coef_we or s_ready, expected both 0 while draining");
        end
        while (nwr < 31 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (coef_we === 1'b1) begin
                tests++;
                if (coef_addr !== 5'(nwr) || coef_wdata !== 32'h4000_0000 + 32'(nwr) ||
                    loaded !== 1'b1 || dut.inflight !== 7'd0) begin
                    fails++;
                    $display("FAIL reload_write: got addr %0d data %0h expected addr %0d data %0h",
                             coef_addr, coef_wdata, nwr, 32'h4000_0000 + 32'(nwr));
                end
                nwr++;
            end
        end
        @(negedge clk);
        tests++;
        if (nwr != 31 || s_ready !== 1'b1 || coef_we !== 1'b0) begin
            fails++;
            $display("FAIL reload_done: got %0d writes s_ready %b expected 31 writes s_ready 1", nwr, s_ready);
        end
    endtask

    task automatic test_underflow();
        int n = 0;
        int guard = 0;
        tests++;
        if (cnt_err !== 1'b0) begin
            fails++;
            $display("FAIL uf_pre: got cnt_err %b expected 0", cnt_err);
        end
        man_out = 1'b1;
        @(negedge clk);
        man_out = 1'b0;
        @(negedge clk);
        tests++;
        if (cnt_err !== 1'b1 || dut.inflight !== 7'd0) begin
            fails++;
            $display("FAIL uf_flag: got cnt_err %b inflight %0d expected 1 0", cnt_err, dut.inflight);
        end
        s_valid = 1'b1;
        while (n < 2 && guard < 20) begin
            s_data = 32'h6600_0000 + 32'(n);
            if (s_ready === 1'b1) n++;
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (dut.inflight !== 7'd2) begin
            fails++;
            $display("FAIL uf_two: got inflight %0d expected 2", dut.inflight);
        end
        s_valid = 1'b1;
        s_data  = 32'h6600_00FF;
        @(negedge clk);
        s_valid = 1'b0;
        man_out = 1'b1;
        tests++;
        if (fir_valid_in !== 1'b1) begin
            fails++;
            $display("FAIL uf_issue: got fir_valid_in %b expected 1", fir_valid_in);
        end
        @(negedge clk);
        man_out = 1'b0;
        tests++;
        if (dut.inflight !== 7'd2) begin
            fails++;
            $display("FAIL uf_simul: got inflight %0d expected 2", dut.inflight);
        end
        man_out = 1'b1;
        repeat (2) @(negedge clk);
        man_out = 1'b0;
        @(negedge clk);
        tests++;
        if (dut.inflight !== 7'd0 || cnt_err !== 1'b1) begin
            fails++;
            $display("FAIL uf_sticky: got inflight %0d cnt_err %b expected 0 1", dut.inflight, cnt_err);
        end
    endtask

    task automatic test_reset_mid_write();
        int g = 0;
        send_cfg(32'h4040_0000);
        while (!(coef_we === 1'b1 && coef_addr === 5'd12) && g < 80) begin
            @(negedge clk);
            g++;
        end
        tests++;
        if (g >= 80) begin
            fails++;
            $display("FAIL midw_reach: got no write at addr 12, expected one");
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({cfg_ready, s_ready, fir_valid_in, coef_we, loaded, cnt_err} !== 6'b0 ||
            coef_addr !== 5'd0 || coef_wdata !== 32'd0 || fir_data_in !== 32'd0) begin
            fails++;
            $display("FAIL midw_async: got flags %b addr %0d wdata %0h expected all 0",
                     {cfg_ready, s_ready, fir_valid_in, coef_we, loaded, cnt_err}, coef_addr, coef_wdata);
        end
        tests++;
        if (dut.state !== 2'd0 || dut.shadow_cnt !== 5'd0 || dut.inflight !== 7'd0) begin
            fails++;
            $display("FAIL midw_state: got state %0d cnt %0d inflight %0d expected 0 0 0",
                     dut.state, dut.shadow_cnt, dut.inflight);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (cfg_ready !== 1'b1 || s_ready !== 1'b0 || loaded !== 1'b0 || coef_we !== 1'b0) begin
            fails++;
            $display("FAIL midw_release: got cfg_ready %b s_ready %b loaded %b we %b expected 1 0 0 0",
                     cfg_ready, s_ready, loaded, coef_we);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_max_inflight();
        test_stream();
        test_reload();
        test_underflow();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule
